control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter IR_W, default 32, instruction register width (>=32; opcode is always ir[IR_W-1:IR_W-5]).
REQ-002 Parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-003 Parameter WAIT_MAX, default 15, maximum memory-wait cycles before fault (1..255).
REQ-004 Port: clock  in  1  single system clock, all state on rising edge.
REQ-005 Port: nRst  in  1  reset, asynchronous, active-low.
REQ-006 Port: ir  in  IR_W  current instruction, stable from DECODE through WB.
REQ-007 Port: run  in  1  start or resume from IDLE.
REQ-008 Port: mem_ready  in  1  memory handshake; current read or write is complete this cycle.
REQ-009 Port: cond_true  in  1  branch condition result from datapath, sampled in EXEC.
REQ-010 Port: ir_enable, pc_enable, ra_enable, rb_enable, rz_enable, rm_enable, ry_enable  out  1 each  register load strobes.
REQ-011 Port: mem_read, mem_write, rf_write, mb_select  out  1 each  memory, register-file and B-mux controls (mb_select=1 selects immediate).
REQ-012 Port: alu_control  out  4  ALU operation code.
REQ-013 Port: phase  out  3  current state encoding.
REQ-014 Port: halted, fault  out  1 each  status flags.
REQ-015 Port: retired  out  CNT_W  count of completed instructions.

Function
REQ-016 The FSM SHALL use states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; phase SHALL equal the state code; code 7 SHALL go to HALT with fault=1.
REQ-017 The FSM SHALL move IDLE->FETCH only when run=1.
REQ-018 In FETCH, mem_read SHALL be 1 each cycle; on mem_ready=1, ir_enable and pc_enable SHALL pulse for that cycle and the FSM SHALL move to DECODE.
REQ-019 In DECODE, ra_enable and rb_enable SHALL be 1 for one cycle; the FSM SHALL then move to EXEC.
REQ-020 Opcodes SHALL be classed as: load 00000/00001, store 00010, ALU-reg 00011-01011, ALU-imm 01100-01110, branch 10011, halt 11011, nop 11010; all other opcodes are illegal.
REQ-021 mb_select SHALL be 1 in EXEC for load, store and ALU-imm, and 0 otherwise.
REQ-022 alu_control SHALL be 0 (add) for load, store and branch, opcode[3:0] for ALU-reg, and opcode-9 truncated to 4 bits for ALU-imm; it SHALL be 0 outside EXEC.
REQ-023 In EXEC, rz_enable SHALL be 1; the FSM SHALL then move to MEM for load or store, to WB for ALU classes, and to FETCH for branch or nop.
REQ-024 For a branch in EXEC, pc_enable SHALL equal cond_true.
REQ-025 In MEM, rm_enable SHALL be 1 on entry; mem_read (load) or mem_write (store) SHALL be held until mem_ready=1; a load then goes to WB with ry_enable=1 in that cycle, and a store goes to FETCH.
REQ-026 In WB, rf_write SHALL be 1 for one cycle; the FSM SHALL then move to FETCH.
REQ-027 A wait counter SHALL clear on entering FETCH or MEM and count each cycle mem_ready=0; when it reaches WAIT_MAX with mem_ready still 0, fault SHALL be set and the FSM SHALL go to HALT the next cycle.
REQ-028 retired SHALL increment by 1 in the cycle the FSM leaves WB, or leaves EXEC/MEM directly to FETCH, and SHALL wrap from all-ones to 0.
REQ-029 The halt opcode in EXEC and any illegal opcode SHALL go to HALT; an illegal opcode SHALL also set fault=1.
REQ-030 In HALT, halted SHALL be 1 and all strobes SHALL be 0; run=1 with fault=0 SHALL move HALT->FETCH; with fault=1, HALT SHALL be left only by reset.
REQ-031 Strobes SHALL be Moore/Mealy decodes of the state and inputs only, and no two of mem_read and mem_write SHALL ever be 1 together.

Reset
REQ-032 nRst=0 SHALL immediately force IDLE, retired=0, fault=0, halted=0, the wait counter to 0, and all strobes and alu_control to 0, including mid-memory-wait.
REQ-033 After nRst deasserts, the first active edge SHALL evaluate from IDLE.

Verification
REQ-034 add (00011), run=1, mem_ready=1 always -> phase 1,2,3,5,1; rf_write=1 in cycle 5; alu_control=3 in EXEC; retired=1.
REQ-035 load, mem_ready low for 3 cycles in MEM -> mem_read held 4 cycles, ry_enable on the 4th, WB follows; retired increments once.
REQ-036 branch with cond_true=0 then 1 -> pc_enable=0 then 1 in EXEC; no WB state visited.
REQ-037 WAIT_MAX=4, mem_ready=0 in FETCH -> fault=1 and phase=6 after 5 cycles; run=1 does not leave HALT.
REQ-038 opcode 11111 -> HALT with fault=1; halt opcode -> HALT with fault=0, and run=1 resumes FETCH.
REQ-039 CNT_W=2, 5 nops -> retired sequence 1,2,3,0,1; nRst pulse mid-MEM -> all outputs 0 asynchronously and phase=0.

Source files
------------

// File: rtl/control_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer_if
// Description : Bundle of every signal between the control sequencer and the
//               datapath/memory side.
//               Inputs to the sequencer : ir, run, mem_ready, cond_true
//               Outputs of the sequencer: register load strobes, memory and
//               register-file controls, alu_control, phase, halted, fault,
//               retired.
//               master = sequencer side, slave = datapath/memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface control_sequencer_if #(
  parameter int IR_W  = 32,
  parameter int CNT_W = 16
);
  logic [IR_W-1:0]  ir;
  logic             run;
  logic             mem_ready;
  logic             cond_true;

  logic             ir_enable;
  logic             pc_enable;
  logic             ra_enable;
  logic             rb_enable;
  logic             rz_enable;
  logic             rm_enable;
  logic             ry_enable;
  logic             mem_read;
  logic             mem_write;
  logic             rf_write;
  logic             mb_select;
  logic [3:0]       alu_control;
  logic [2:0]       phase;
  logic             halted;
  logic             fault;
  logic [CNT_W-1:0] retired;

  modport master (
    input  ir, run, mem_ready, cond_true,
    output ir_enable, pc_enable, ra_enable, rb_enable, rz_enable, rm_enable,
           ry_enable, mem_read, mem_write, rf_write, mb_select, alu_control,
           phase, halted, fault, retired
  );

  modport slave (
    output ir, run, mem_ready, cond_true,
    input  ir_enable, pc_enable, ra_enable, rb_enable, rz_enable, rm_enable,
           ry_enable, mem_read, mem_write, rf_write, mb_select, alu_control,
           phase, halted, fault, retired
  );
endinterface
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Multi-cycle processor control FSM. Walks each instruction
//               through FETCH, DECODE, EXEC, optional MEM and WB, drives the
//               datapath load strobes, guards memory handshakes with a wait
//               timeout, and counts retired instructions.
// Ports       : clock - system clock, rising edge
//               nRst  - asynchronous active-low reset
//               bus   - control_sequencer_if.master (instruction, handshake,
//                       strobes, status)
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer #(
  parameter int IR_W     = 32,
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic                clock,
  input  logic                nRst,
  control_sequencer_if.master bus
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_FETCH  = 3'd1;
  localparam logic [2:0] c_DECODE = 3'd2;
  localparam logic [2:0] c_EXEC   = 3'd3;
  localparam logic [2:0] c_MEM    = 3'd4;
  localparam logic [2:0] c_WB     = 3'd5;
  localparam logic [2:0] c_HALT   = 3'd6;

  localparam logic [7:0] c_WAIT_MAX = 8'(WAIT_MAX);

  logic [2:0]       r_state;
  logic [2:0]       w_next_state;
  logic [7:0]       r_wait;
  logic             r_fault;
  logic [CNT_W-1:0] r_retired;

  logic             w_fault_set;
  logic             w_retire;
  logic             w_wait_state;
  logic             w_enter_wait_state;
  logic             w_wait_expired;

  logic [4:0]       w_opcode;
  logic [4:0]       w_imm_alu;
  logic             w_is_load;
  logic             w_is_store;
  logic             w_is_alu_reg;
  logic             w_is_alu_imm;
  logic             w_is_branch;
  logic             w_is_halt;
  logic             w_is_nop;
  logic             w_unused_bits;

  // --------------------------------------------------------------------------
  // Opcode classification
  // --------------------------------------------------------------------------
  assign w_opcode     = bus.ir[IR_W-1 -: 5];
  assign w_is_load    = (w_opcode == 5'b00000) || (w_opcode == 5'b00001);
  assign w_is_store   = (w_opcode == 5'b00010);
  assign w_is_alu_reg = (w_opcode >= 5'b00011) && (w_opcode <= 5'b01011);
  assign w_is_alu_imm = (w_opcode >= 5'b01100) && (w_opcode <= 5'b01110);
  assign w_is_branch  = (w_opcode == 5'b10011);
  assign w_is_halt    = (w_opcode == 5'b11011);
  assign w_is_nop     = (w_opcode == 5'b11010);
  // Immediate ALU ops 12..14 map onto ALU codes 3..5.
  assign w_imm_alu    = w_opcode - 5'd9;

  assign w_unused_bits = w_imm_alu[4] ^ (^bus.ir[IR_W-6:0]);

  // --------------------------------------------------------------------------
  // Memory wait tracking: the counter restarts on every entry into a state
  // that waits on mem_ready and advances on every stalled cycle there.
  // --------------------------------------------------------------------------
  assign w_wait_state       = (r_state == c_FETCH) || (r_state == c_MEM);
  assign w_enter_wait_state = (w_next_state != r_state) &&
                              ((w_next_state == c_FETCH) || (w_next_state == c_MEM));
  assign w_wait_expired     = (r_wait == c_WAIT_MAX);

  // --------------------------------------------------------------------------
  // State register and status registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge nRst) begin
    if (!nRst) begin
      r_state   <= c_IDLE;
      r_wait    <= 8'd0;
      r_fault   <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_enter_wait_state) begin
        r_wait <= 8'd0;
      end else if (w_wait_state && !bus.mem_ready && !w_wait_expired) begin
        r_wait <= r_wait + 8'd1;
      end
      if (w_fault_set) begin
        r_fault <= 1'b1;
      end
      if (w_retire) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_fault_set  = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (bus.run) w_next_state = c_FETCH;
      end
      c_FETCH: begin
        if (bus.mem_ready) begin
          w_next_state = c_DECODE;
        end else if (w_wait_expired) begin
          w_next_state = c_HALT;
          w_fault_set  = 1'b1;
        end
      end
      c_DECODE: begin
        w_next_state = c_EXEC;
      end
      c_EXEC: begin
        if (w_is_load || w_is_store) begin
          w_next_state = c_MEM;
        end else if (w_is_alu_reg || w_is_alu_imm) begin
          w_next_state = c_WB;
        end else if (w_is_branch || w_is_nop) begin
          w_next_state = c_FETCH;
          w_retire     = 1'b1;
        end else if (w_is_halt) begin
          w_next_state = c_HALT;
        end else begin
          w_next_state = c_HALT;
          w_fault_set  = 1'b1;
        end
      end
      c_MEM: begin
        if (bus.mem_ready) begin
          if (w_is_load) begin
            w_next_state = c_WB;
          end else begin
            w_next_state = c_FETCH;
            w_retire     = 1'b1;
          end
        end else if (w_wait_expired) begin
          w_next_state = c_HALT;
          w_fault_set  = 1'b1;
        end
      end
      c_WB: begin
        w_next_state = c_FETCH;
        w_retire     = 1'b1;
      end
      c_HALT: begin
        // A faulted sequencer can only be recovered by reset.
        if (bus.run && !r_fault) w_next_state = c_FETCH;
      end
      default: begin
        w_next_state = c_HALT;
        w_fault_set  = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  always_comb begin
    bus.ir_enable   = 1'b0;
    bus.pc_enable   = 1'b0;
    bus.ra_enable   = 1'b0;
    bus.rb_enable   = 1'b0;
    bus.rz_enable   = 1'b0;
    bus.rm_enable   = 1'b0;
    bus.ry_enable   = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.rf_write    = 1'b0;
    bus.mb_select   = 1'b0;
    bus.alu_control = 4'd0;
    case (r_state)
      c_FETCH: begin
        bus.mem_read = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_enable = 1'b1;
          bus.pc_enable = 1'b1;
        end
      end
      c_DECODE: begin
        bus.ra_enable = 1'b1;
        bus.rb_enable = 1'b1;
      end
      c_EXEC: begin
        bus.rz_enable = 1'b1;
        bus.mb_select = w_is_load || w_is_store || w_is_alu_imm;
        bus.pc_enable = w_is_branch && bus.cond_true;
        if (w_is_alu_reg) begin
          bus.alu_control = w_opcode[3:0];
        end else if (w_is_alu_imm) begin
          bus.alu_control = w_imm_alu[3:0];
        end
      end
      c_MEM: begin
        // The wait counter is zero only in the first MEM cycle.
        bus.rm_enable = (r_wait == 8'd0);
        if (w_is_load) begin
          bus.mem_read  = 1'b1;
          bus.ry_enable = bus.mem_ready;
        end else begin
          bus.mem_write = 1'b1;
        end
      end
      c_WB: begin
        bus.rf_write = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.phase   = r_state;
  assign bus.halted  = (r_state == c_HALT);
  assign bus.fault   = r_fault;
  assign bus.retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Self-checking bench for control_sequencer. Instructions are
//               walked phase by phase; each cycle's expected strobes, phase
//               and status come from the instruction-level rules (class of
//               opcode, memory wait count, branch condition).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

  localparam int IR_W     = 32;
  localparam int CNT_W    = 2;
  localparam int WAIT_MAX = 4;

  localparam logic [10:0] B_IR = 11'b100_0000_0000;
  localparam logic [10:0] B_PC = 11'b010_0000_0000;
  localparam logic [10:0] B_RA = 11'b001_0000_0000;
  localparam logic [10:0] B_RB = 11'b000_1000_0000;
  localparam logic [10:0] B_RZ = 11'b000_0100_0000;
  localparam logic [10:0] B_RM = 11'b000_0010_0000;
  localparam logic [10:0] B_RY = 11'b000_0001_0000;
  localparam logic [10:0] B_MR = 11'b000_0000_1000;
  localparam logic [10:0] B_MW = 11'b000_0000_0100;
  localparam logic [10:0] B_RF = 11'b000_0000_0010;
  localparam logic [10:0] B_MB = 11'b000_0000_0001;

  typedef enum int {K_LOAD, K_STORE, K_ALUR, K_ALUI, K_BR, K_HALT, K_NOP, K_ILL} kind_t;

  logic        clock = 1'b0;
  logic        nRst  = 1'b0;
  logic [31:0] cur_ir = 32'd0;
  int          errors = 0;
  int          checks = 0;
  int          model_retired = 0;
  logic        model_fault = 1'b0;

  control_sequencer_if #(.IR_W(IR_W), .CNT_W(CNT_W)) bus ();

  control_sequencer #(.IR_W(IR_W), .CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clock (clock),
    .nRst  (nRst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] obs_strobes();
    return {bus.ir_enable, bus.pc_enable, bus.ra_enable, bus.rb_enable,
            bus.rz_enable, bus.rm_enable, bus.ry_enable, bus.mem_read,
            bus.mem_write, bus.rf_write, bus.mb_select};
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle: drive inputs on the falling edge, check, then let the
  // rising edge happen.
  task automatic cyc(input string tag, input logic mr, input logic rn, input logic ct,
                     input logic [10:0] es, input logic [3:0] ea, input logic [2:0] ep);
    @(negedge clock);
    bus.ir        = cur_ir;
    bus.mem_ready = mr;
    bus.run       = rn;
    bus.cond_true = ct;
    #1;
    check({tag, ".phase"},   32'(bus.phase),       32'(ep));
    check({tag, ".strobes"}, 32'(obs_strobes()),   32'(es));
    check({tag, ".alu"},     32'(bus.alu_control), 32'(ea));
    check({tag, ".halted"},  32'(bus.halted),      32'(ep == 3'd6));
    check({tag, ".fault"},   32'(bus.fault),       32'(model_fault));
    check({tag, ".retired"}, 32'(bus.retired),     32'(model_retired % (1 << CNT_W)));
    @(posedge clock);
  endtask

  // Reset asserted between clock edges; everything must clear at once.
  task automatic do_reset();
    @(negedge clock);
    bus.run       = 1'b0;
    bus.mem_ready = 1'b0;
    #2 nRst = 1'b0;
    #1;
    model_retired = 0;
    model_fault   = 1'b0;
    check("rst.phase",   32'(bus.phase),       32'd0);
    check("rst.strobes", 32'(obs_strobes()),   32'd0);
    check("rst.alu",     32'(bus.alu_control), 32'd0);
    check("rst.halted",  32'(bus.halted),      32'd0);
    check("rst.fault",   32'(bus.fault),       32'd0);
    check("rst.retired", 32'(bus.retired),     32'd0);
    @(posedge clock);
    @(negedge clock);
    nRst = 1'b1;
  endtask

  task automatic leave_idle();
    cyc("idle_hold", rnd_bit(), 1'b0, rnd_bit(), 11'd0, 4'd0, 3'd0);
    cyc("idle_go",   rnd_bit(), 1'b1, rnd_bit(), 11'd0, 4'd0, 3'd0);
  endtask

  function automatic logic [4:0] pick_op(input kind_t k);
    int ill [14] = '{15, 16, 17, 18, 20, 21, 22, 23, 24, 25, 28, 29, 30, 31};
    case (k)
      K_LOAD:  return 5'($urandom_range(0, 1));
      K_STORE: return 5'd2;
      K_ALUR:  return 5'($urandom_range(3, 11));
      K_ALUI:  return 5'($urandom_range(12, 14));
      K_BR:    return 5'd19;
      K_HALT:  return 5'd27;
      K_NOP:   return 5'd26;
      default: return 5'(ill[$urandom_range(0, 13)]);
    endcase
  endfunction

  function automatic kind_t pick_kind();
    int r = $urandom_range(0, 19);
    if (r < 3)  return K_LOAD;
    if (r < 5)  return K_STORE;
    if (r < 9)  return K_ALUR;
    if (r < 11) return K_ALUI;
    if (r < 14) return K_BR;
    if (r < 15) return K_HALT;
    if (r < 17) return K_NOP;
    if (r < 18) return K_ILL;
    return K_ALUR;
  endfunction

  // res: 0 = next cycle is FETCH, 1 = next cycle is HALT, 2 = reset to IDLE
  task automatic run_instr(input kind_t k, input logic [4:0] op, input logic ct,
                           input int fw, input int mw, input int rst_mem, output int res);
    logic [10:0] es;
    logic [3:0]  ea;
    logic        mr;
    res    = 0;
    cur_ir = {op, 27'($urandom())};
    for (int i = 0; i <= WAIT_MAX; i++) begin
      mr = (i == fw);
      es = B_MR | (mr ? (B_IR | B_PC) : 11'd0);
      cyc("fetch", mr, rnd_bit(), rnd_bit(), es, 4'd0, 3'd1);
      if (mr) break;
      if (i == WAIT_MAX) begin
        model_fault = 1'b1;
        res = 1;
        return;
      end
    end
    cyc("decode", rnd_bit(), rnd_bit(), rnd_bit(), B_RA | B_RB, 4'd0, 3'd2);
    es = B_RZ;
    ea = 4'd0;
    if (k == K_LOAD || k == K_STORE || k == K_ALUI) es |= B_MB;
    if (k == K_BR && ct) es |= B_PC;
    if (k == K_ALUR) ea = 4'(int'(op));
    if (k == K_ALUI) ea = 4'(int'(op) - 9);
    cyc("exec", rnd_bit(), rnd_bit(), ct, es, ea, 3'd3);
    case (k)
      K_BR, K_NOP: begin model_retired++; return; end
      K_HALT:      begin res = 1; return; end
      K_ILL:       begin model_fault = 1'b1; res = 1; return; end
      default: ;
    endcase
    if (k == K_LOAD || k == K_STORE) begin
      for (int i = 0; i <= WAIT_MAX; i++) begin
        if (i == rst_mem) begin
          do_reset();
          res = 2;
          return;
        end
        mr = (i == mw);
        es = (k == K_LOAD) ? B_MR : B_MW;
        if (i == 0) es |= B_RM;
        if (k == K_LOAD && mr) es |= B_RY;
        cyc("mem", mr, rnd_bit(), rnd_bit(), es, 4'd0, 3'd4);
        if (mr) break;
        if (i == WAIT_MAX) begin
          model_fault = 1'b1;
          res = 1;
          return;
        end
      end
      if (k == K_STORE) begin
        model_retired++;
        return;
      end
    end
    cyc("wb", rnd_bit(), rnd_bit(), rnd_bit(), B_RF, 4'd0, 3'd5);
    model_retired++;
  endtask

  task automatic handle_halt();
    cyc("halt_wait", rnd_bit(), 1'b0, rnd_bit(), 11'd0, 4'd0, 3'd6);
    cyc("halt_run",  rnd_bit(), 1'b1, rnd_bit(), 11'd0, 4'd0, 3'd6);
    if (model_fault) begin
      cyc("halt_stuck", rnd_bit(), 1'b1, rnd_bit(), 11'd0, 4'd0, 3'd6);
      do_reset();
      leave_idle();
    end
  endtask

  task automatic follow_up(input int res);
    if (res == 1) handle_halt();
    else if (res == 2) leave_idle();
  endtask

  initial begin
    int res;
    bus.ir        = 32'd0;
    bus.run       = 1'b0;
    bus.mem_ready = 1'b0;
    bus.cond_true = 1'b0;
    #1;
    check("init.phase",   32'(bus.phase),       32'd0);
    check("init.strobes", 32'(obs_strobes()),   32'd0);
    check("init.retired", 32'(bus.retired),     32'd0);
    check("init.fault",   32'(bus.fault),       32'd0);
    @(negedge clock);
    nRst = 1'b1;
    leave_idle();

    // Directed cases
    run_instr(K_ALUR, 5'd3,  1'b0, 0, 0, -1, res); follow_up(res);
    run_instr(K_LOAD, 5'd0,  1'b0, 0, 3, -1, res); follow_up(res);
    run_instr(K_BR,   5'd19, 1'b0, 1, 0, -1, res); follow_up(res);
    run_instr(K_BR,   5'd19, 1'b1, 0, 0, -1, res); follow_up(res);
    run_instr(K_STORE, 5'd2, 1'b0, 2, 1, -1, res); follow_up(res);
    run_instr(K_ALUI, 5'd14, 1'b0, 0, 0, -1, res); follow_up(res);
    run_instr(K_ALUR, 5'd3,  1'b0, WAIT_MAX + 1, 0, -1, res); follow_up(res);
    run_instr(K_ILL,  5'd31, 1'b0, 0, 0, -1, res); follow_up(res);
    run_instr(K_HALT, 5'd27, 1'b0, 0, 0, -1, res); follow_up(res);
    for (int n = 0; n < 5; n++) begin
      run_instr(K_NOP, 5'd26, 1'b0, 0, 0, -1, res); follow_up(res);
    end
    run_instr(K_LOAD, 5'd1,  1'b0, 0, 10, 2, res); follow_up(res);
    run_instr(K_STORE, 5'd2, 1'b0, 0, WAIT_MAX + 1, -1, res); follow_up(res);

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      kind_t      k;
      logic [4:0] op;
      int         fw, mw, rm;
      k  = pick_kind();
      op = pick_op(k);
      fw = ($urandom_range(0, 11) == 0) ? WAIT_MAX + 1 : $urandom_range(0, 3);
      mw = ($urandom_range(0, 11) == 0) ? WAIT_MAX + 1 : $urandom_range(0, 3);
      rm = ($urandom_range(0, 24) == 0) ? $urandom_range(0, 2) : -1;
      run_instr(k, op, rnd_bit(), fw, mw, rm, res);
      follow_up(res);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not complete");
  end

endmodule
`default_nettype wire
